// File: rtl/ucaspian_pkg.sv
// ucaspian_pkg
//   Shared definitions for the synapse lanes and the dendrite/charge
//   accumulator: default field widths, the packed synapse memory entry
//   and a helper that builds an entry from its two fields.
package ucaspian_pkg;

    localparam int SYN_ADDR_W     = 10;
    localparam int SYN_WEIGHT_W   = 8;
    localparam int SYN_TARGET_W   = 8;
    localparam int SYN_FIFO_DEPTH = 3;

    // Layout of one synapse memory word: {weight[15:8] signed, target[7:0]}.
    typedef struct packed {
        logic signed [SYN_WEIGHT_W-1:0] weight;
        logic        [SYN_TARGET_W-1:0] target;
    } syn_entry_t;

    function automatic syn_entry_t syn_pack(input logic signed [SYN_WEIGHT_W-1:0] weight,
                                            input logic        [SYN_TARGET_W-1:0] target);
        syn_entry_t e;
        e.weight = weight;
        e.target = target;
        return e;
    endfunction

endpackage

// File: rtl/synapse_unit_syn_mem.sv
// syn_mem
//   Single-port synchronous synapse RAM (2^ADDR_W x DATA_W), one-cycle read
//   latency, written as a plain BRAM template. A write takes the port for
//   that cycle; the read register then keeps its previous value.
//
// Ports
//   clk      clock
//   wr_en    write strobe (has priority over rd_en)
//   rd_en    read strobe; rd_data is valid the following cycle
//   addr     shared read/write address
//   wr_data  write data
//   rd_data  registered read data
module syn_mem #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end else if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/synapse_unit.sv
// synapse_unit
//   One synapse lane. Takes a synapse address per valid/ready handshake,
//   looks it up in the synapse RAM and forwards non-zero-weight entries to
//   the dendrite accumulator through a small output FIFO. Acceptance is
//   credit based (FIFO occupancy plus the read in flight), so syn_rdy never
//   depends on out_rdy and a full FIFO is never pushed.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   enable              step enable; gates new accepts and FIFO pops
//   cfg_wr_en/addr/data synapse RAM write port ({weight, target})
//   syn_vld/addr/rdy    address stream from the fire dispatcher
//   out_vld/weight/target/rdy  result stream to the accumulator
//   step_done           registered: lane idle, drained, nothing offered
module synapse_unit
    import ucaspian_pkg::*;
#(
    parameter int ADDR_W     = SYN_ADDR_W,
    parameter int WEIGHT_W   = SYN_WEIGHT_W,
    parameter int TARGET_W   = SYN_TARGET_W,
    parameter int FIFO_DEPTH = SYN_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         cfg_wr_en,
    input  logic [ADDR_W-1:0]            cfg_addr,
    input  logic [WEIGHT_W+TARGET_W-1:0] cfg_data,
    input  logic                         syn_vld,
    input  logic [ADDR_W-1:0]            syn_addr,
    output logic                         syn_rdy,
    output logic                         out_vld,
    output logic [WEIGHT_W-1:0]          out_weight,
    output logic [TARGET_W-1:0]          out_target,
    input  logic                         out_rdy,
    output logic                         step_done
);

    localparam int DATA_W = WEIGHT_W + TARGET_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  wr_idx;
    logic [CNT_W:0]    credits_used;
    logic              rd_pending;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] entries [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic              accept;
    logic              push;
    logic              pop;

    // The read in flight reserves a FIFO slot, so a push always has room.
    assign credits_used = {1'b0, count} + (CNT_W+1)'(rd_pending);
    assign syn_rdy      = enable & ~cfg_wr_en & ~reset & (credits_used < DEPTH_EXT);
    assign accept       = syn_vld & syn_rdy;

    assign mem_wr_en = cfg_wr_en & ~reset;
    assign mem_addr  = cfg_wr_en ? cfg_addr : syn_addr;

    syn_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_syn_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .rd_en   (accept),
        .addr    (mem_addr),
        .wr_data (cfg_data),
        .rd_data (rd_data)
    );

    // Zero-weight synapses carry no charge and are dropped here.
    assign push    = rd_pending & (rd_data[DATA_W-1:TARGET_W] != '0);
    assign out_vld = (count != '0);
    assign pop     = out_vld & out_rdy & enable;

    // Head lives in entries[0]; a pop shifts down, so the new entry lands
    // one slot lower when a pop happens in the same cycle.
    assign wr_idx = pop ? (count - ONE_CNT) : count;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + ONE_CNT;
            2'b01:   count_next = count - ONE_CNT;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            rd_pending <= 1'b0;
            step_done  <= 1'b1;
        end else begin
            count      <= count_next;
            rd_pending <= accept;
            step_done  <= (count_next == '0) & ~accept & ~syn_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (pop) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                    entries[i] <= entries[i+1];
                end
            end
            if (push) begin
                entries[wr_idx] <= rd_data;
            end
        end
    end

    assign out_weight = out_vld ? entries[0][DATA_W-1:TARGET_W] : '0;
    assign out_target = out_vld ? entries[0][TARGET_W-1:0]      : '0;

    // A push into a full FIFO means the credit accounting is broken.
    fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count == DEPTH_CNT)));

endmodule

// File: tb/tb_synapse_unit.sv
module tb_synapse_unit;
    import ucaspian_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cfg_wr_en;
    logic [9:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        syn_vld;
    logic [9:0]  syn_addr;
    logic        syn_rdy;
    logic        out_vld;
    logic [7:0]  out_weight;
    logic [7:0]  out_target;
    logic        out_rdy;
    logic        step_done;

    int errors = 0;
    int checks = 0;
    int accepts = 0;
    int pops = 0;

    // Reference model: contents of synapse memory as written, and the ordered
    // list of non-zero entries accepted but not yet delivered downstream.
    logic [15:0] shadow [1024];
    logic [15:0] exp_q [$];

    synapse_unit dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cfg_wr_en  (cfg_wr_en),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .syn_vld    (syn_vld),
        .syn_addr   (syn_addr),
        .syn_rdy    (syn_rdy),
        .out_vld    (out_vld),
        .out_weight (out_weight),
        .out_target (out_target),
        .out_rdy    (out_rdy),
        .step_done  (step_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard update for the current (settled) cycle, then move to the
    // next drive point.
    task automatic adv();
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_vld && out_rdy && enable) begin
                pops++;
                chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("pop_data", {16'd0, out_weight, out_target}, {16'd0, exp_q[0]});
                    void'(exp_q.pop_front());
                end
            end
            if (syn_vld && syn_rdy) begin
                accepts++;
                if (shadow[syn_addr][15:8] != 8'd0) exp_q.push_back(shadow[syn_addr]);
            end
            if (cfg_wr_en) shadow[cfg_addr] = cfg_data;
        end
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [9:0] a, input logic [15:0] d);
        cfg_wr_en = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        settle();
        adv();
        cfg_wr_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        syn_vld   = 1'b0;
        cfg_wr_en = 1'b0;
        enable    = 1'b1;
        out_rdy   = 1'b1;
        settle();
        while (!(step_done === 1'b1 && exp_q.size() == 0) && n < 20) begin
            adv();
            settle();
            n++;
        end
        chk({tag, "_step_done"}, 32'(step_done), 32'd1);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_out_vld"}, 32'(out_vld), 32'd0);
        adv();
    endtask

    initial begin
        int a0;
        int p0;
        reset     = 1'b1;
        enable    = 1'b1;
        cfg_wr_en = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        syn_vld   = 1'b0;
        syn_addr  = '0;
        out_rdy   = 1'b0;

        // Reset state
        @(negedge clk);
        settle();
        chk("rst_syn_rdy", 32'(syn_rdy), 32'd0);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_out_data", {16'd0, out_weight, out_target}, 32'd0);
        chk("rst_step_done", 32'(step_done), 32'd1);
        adv();
        reset = 1'b0;

        // Stream 5,6,7 with out_rdy high; first result two cycles after accept
        cfg_write(10'd5, syn_pack(8'sd3, 8'd12));
        cfg_write(10'd6, syn_pack(-8'sd2, 8'd40));
        cfg_write(10'd7, syn_pack(8'sd1, 8'd0));
        out_rdy = 1'b1;
        syn_vld = 1'b1; syn_addr = 10'd5; settle();
        chk("t1_syn_rdy", 32'(syn_rdy), 32'd1);
        chk("t1_lat_n", 32'(out_vld), 32'd0);
        adv();
        syn_addr = 10'd6; settle();
        chk("t1_lat_n1", 32'(out_vld), 32'd0);
        adv();
        syn_addr = 10'd7; settle();
        chk("t1_lat_n2_vld", 32'(out_vld), 32'd1);
        chk("t1_e0", {16'd0, out_weight, out_target}, {16'd0, 16'(syn_pack(8'sd3, 8'd12))});
        chk("t1_busy", 32'(step_done), 32'd0);
        adv();
        syn_vld = 1'b0; settle();
        chk("t1_e1", {16'd0, out_weight, out_target}, {16'd0, 16'(syn_pack(-8'sd2, 8'd40))});
        adv();
        settle();
        chk("t1_e2_vld", 32'(out_vld), 32'd1);
        chk("t1_e2", {16'd0, out_weight, out_target}, {16'd0, 16'(syn_pack(8'sd1, 8'd0))});
        adv();
        settle();
        chk("t1_empty", 32'(out_vld), 32'd0);
        chk("t1_done", 32'(step_done), 32'd1);
        adv();

        // Zero-weight entry is dropped
        cfg_write(10'd10, syn_pack(8'sd0, 8'd55));
        cfg_write(10'd11, syn_pack(8'sd7, 8'd9));
        syn_vld = 1'b1; syn_addr = 10'd10; settle(); adv();
        syn_addr = 10'd11; settle(); adv();
        syn_vld = 1'b0; settle();
        chk("t2_zero_dropped", 32'(out_vld), 32'd0);
        adv();
        settle();
        chk("t2_vld", 32'(out_vld), 32'd1);
        chk("t2_data", {16'd0, out_weight, out_target}, {16'd0, 16'(syn_pack(8'sd7, 8'd9))});
        adv();
        settle();
        chk("t2_single", 32'(out_vld), 32'd0);
        adv();

        // Backpressure: only three addresses accepted, head stable
        for (int i = 0; i < 6; i++) begin
            cfg_write(10'(i), syn_pack(8'($urandom_range(1, 255)), 8'($urandom_range(0, 255))));
        end
        out_rdy = 1'b0;
        a0 = accepts;
        p0 = pops;
        for (int cyc = 0; cyc < 8; cyc++) begin
            syn_vld = 1'b1;
            syn_addr = 10'(accepts - a0);
            settle();
            if (cyc >= 3) begin
                chk("t3_head_vld", 32'(out_vld), 32'd1);
                chk("t3_head_stable", {16'd0, out_weight, out_target}, {16'd0, shadow[0]});
            end
            if (cyc == 7) chk("t3_syn_rdy_low", 32'(syn_rdy), 32'd0);
            adv();
        end
        chk("t3_accepted_3", 32'(accepts - a0), 32'd3);
        out_rdy = 1'b1;
        for (int n = 0; n < 30 && (accepts - a0) < 6; n++) begin
            syn_vld = 1'b1;
            syn_addr = 10'(accepts - a0);
            settle();
            adv();
        end
        drain("t3_drain");
        chk("t3_accepted_6", 32'(accepts - a0), 32'd6);
        chk("t3_popped_6", 32'(pops - p0), 32'd6);

        // Config write blocks acceptance; next-cycle read sees new data
        cfg_write(10'd20, syn_pack(8'sd9, 8'd9));
        cfg_wr_en = 1'b1; cfg_addr = 10'd20; cfg_data = syn_pack(8'sd5, 8'd3);
        syn_vld = 1'b1; syn_addr = 10'd20; out_rdy = 1'b1;
        settle();
        chk("t4_rdy_blocked", 32'(syn_rdy), 32'd0);
        adv();
        cfg_wr_en = 1'b0; settle();
        chk("t4_rdy_after", 32'(syn_rdy), 32'd1);
        adv();
        syn_vld = 1'b0; settle(); adv();
        settle();
        chk("t4_vld", 32'(out_vld), 32'd1);
        chk("t4_new_data", {16'd0, out_weight, out_target}, {16'd0, 16'(syn_pack(8'sd5, 8'd3))});
        adv();
        drain("t4_drain");

        // enable low with an in-flight read and buffered entries
        p0 = pops;
        out_rdy = 1'b0;
        syn_vld = 1'b1; syn_addr = 10'd5; settle(); adv();
        syn_addr = 10'd6; settle(); adv();
        enable = 1'b0; out_rdy = 1'b1; syn_addr = 10'd7;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("t5_syn_rdy", 32'(syn_rdy), 32'd0);
            chk("t5_out_vld", 32'(out_vld), 32'd1);
            chk("t5_head", {16'd0, out_weight, out_target}, {16'd0, shadow[5]});
            adv();
        end
        chk("t5_no_pop", 32'(pops - p0), 32'd0);
        drain("t5_drain");
        chk("t5_popped_2", 32'(pops - p0), 32'd2);

        // Reset with two buffered entries and a read in flight
        cfg_write(10'd5, syn_pack(8'sd3, 8'd12));
        out_rdy = 1'b0;
        syn_vld = 1'b1;
        for (int i = 5; i < 8; i++) begin
            syn_addr = 10'(i);
            settle();
            adv();
        end
        syn_vld = 1'b0; reset = 1'b1; settle(); adv();
        reset = 1'b0; settle();
        chk("t6_out_vld", 32'(out_vld), 32'd0);
        chk("t6_step_done", 32'(step_done), 32'd1);
        chk("t6_out_data", {16'd0, out_weight, out_target}, 32'd0);
        chk("t6_syn_rdy", 32'(syn_rdy), 32'd1);
        adv();
        settle();
        chk("t6_inflight_discarded", 32'(out_vld), 32'd0);
        adv();
        syn_vld = 1'b1; syn_addr = 10'd5; out_rdy = 1'b1; settle(); adv();
        syn_vld = 1'b0; settle(); adv();
        settle();
        chk("t6_reread_vld", 32'(out_vld), 32'd1);
        chk("t6_reread", {16'd0, out_weight, out_target}, {16'd0, 16'(syn_pack(8'sd3, 8'd12))});
        adv();
        drain("t6_drain");

        // Randomised traffic against the queue model
        for (int i = 0; i < 32; i++) begin
            if ($urandom_range(0, 3) == 0)
                cfg_write(10'(i), syn_pack(8'sd0, 8'($urandom_range(0, 255))));
            else
                cfg_write(10'(i), syn_pack(8'($urandom_range(1, 255)), 8'($urandom_range(0, 255))));
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset     = ($urandom_range(0, 149) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            out_rdy   = ($urandom_range(0, 9) < 6);
            syn_vld   = ($urandom_range(0, 9) < 7);
            syn_addr  = 10'($urandom_range(0, 31));
            cfg_wr_en = ($urandom_range(0, 9) == 0);
            cfg_addr  = 10'($urandom_range(0, 31));
            cfg_data  = 16'($urandom_range(0, 65535));
            settle();
            if (out_vld) chk("rnd_vld_backed", 32'(exp_q.size() != 0), 32'd1);
            adv();
        end
        reset = 1'b0;
        drain("rnd_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
